// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: register map, bus access encodings and palette defaults
// shared by the vga_fb_scanout framebuffer slice.
package vga_fb_pkg;

  typedef logic [5:0] colour_t;

  localparam logic [5:0] VRAM_BASE   = 6'h00;
  localparam logic [5:0] PAL_BASE    = 6'h30;
  localparam logic [5:0] SCALE       = 6'h34;
  localparam logic [5:0] SCROLL      = 6'h35;
  localparam logic [5:0] WAIT_HBLANK = 6'h00;
  localparam logic [5:0] WAIT_PIXEL0 = 6'h04;
  localparam logic [5:0] WAIT_VBLANK = 6'h08;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;
  localparam logic [1:0] ACC_NONE = 2'b11;

  localparam colour_t PAL0_RST = 6'b010000;
  localparam colour_t PAL1_RST = 6'b001011;
  localparam colour_t PAL2_RST = 6'b110000;
  localparam colour_t PAL3_RST = 6'b000011;

endpackage

// File: rtl/vga_fb_wait_ctrl.sv
// vga_fb_wait_ctrl: CPU stall FSM for HBLANK, pixel-0 and VBLANK waits;
// drives data_ready low from the request until the release event.
module vga_fb_wait_ctrl
  import vga_fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic [5:0] address,
  input  logic       vga_blank,
  input  logic       vga_vsync_in,
  input  logic       index_zero,
  output logic       data_ready
);

  typedef enum logic [1:0] {
    IDLE,
    W_HBL,
    W_PX0,
    W_VBL
  } wstate_t;

  wstate_t state, state_nx, hit;
  logic    blank_q, vsync_q;
  logic    blank_rise, vsync_rise, req;

  assign blank_rise = vga_blank & ~blank_q;
  assign vsync_rise = vga_vsync_in & ~vsync_q;
  // a simultaneous write wins, so no wait starts
  assign req = rd_req & ~wr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      blank_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_nx;
      blank_q <= vga_blank;
      vsync_q <= vga_vsync_in;
    end
  end

  always_comb begin
    hit = IDLE;
    unique case (1'b1)
      (address == WAIT_HBLANK): hit = W_HBL;
      (address == WAIT_PIXEL0): hit = W_PX0;
      (address == WAIT_VBLANK): hit = W_VBL;
      default:                  hit = IDLE;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = hit;
      W_HBL:   if (blank_rise) state_nx = IDLE;
      W_PX0:   if (index_zero && !vga_blank) state_nx = IDLE;
      W_VBL:   if (vsync_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    data_ready = (state == IDLE) && !(req && (hit != IDLE));
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: BPP-bit VRAM framebuffer with palette, pixel scaling
// and CPU stalls. VGA_FB_SCROLL_EN adds the frame_start scroll register.
module vga_fb_scanout
  import vga_fb_pkg::*;
#(
  parameter int PIXEL_COUNT = 320,
  parameter int BPP         = 1,
  parameter int X_SCALE_RST = 57,
  parameter int Y_SCALE_RST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  input  logic [9:0]  vga_y,
  input  logic        vga_blank,
  input  logic        vga_new_scanline,
  input  logic        vga_hsync_in,
  input  logic        vga_vsync_in,
  output logic [5:0]  bbggrr,
  output logic        hsync,
  output logic        vsync
);

  localparam int IW    = $clog2(PIXEL_COUNT);
  localparam int VBITS = PIXEL_COUNT * BPP;
  localparam int WORDS = VBITS / 32;
  localparam int BW    = $clog2(VBITS);
  localparam logic [IW-1:0] LAST = IW'(PIXEL_COUNT - 1);

  if ((VBITS % 32) != 0 || VBITS > 384 ||
      (BPP != 1 && BPP != 2)) begin : g_bad_cfg
    $error("vga_fb_scanout: bad PIXEL_COUNT/BPP");
  end

  logic          wr, rd;
  logic [5:0]    vram_off;
  logic [3:0]    lanes;
  logic [31:0]   wdata;
  logic [31:0]   vram [WORDS];
  logic [VBITS-1:0] vram_flat;
  colour_t       pal [4];
  logic [6:0]    x_scale, y_scale;
  logic [6:0]    x_cnt, y_cnt;
  logic [IW-1:0] index, row_start, frame_start;
  logic [BW-1:0] bit_idx;
  logic [BPP-1:0] px;
  logic          vsync_rise;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  assign wr       = data_write_n != ACC_NONE;
  assign rd       = data_read_n != ACC_NONE;
  assign vram_off = address - VRAM_BASE;
  assign data_out = {22'd0, vga_y};

  // narrow writes arrive in the low lanes of data_in
  always_comb begin
    lanes = 4'b0000;
    wdata = data_in;
    unique case (1'b1)
      (data_write_n == ACC_BYTE): begin
        lanes = 4'b0001 << vram_off[1:0];
        wdata = {4{data_in[7:0]}};
      end
      (data_write_n == ACC_HALF): begin
        lanes = vram_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      (data_write_n == ACC_WORD): lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr && 32'(vram_off[5:2]) < WORDS) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) vram[vram_off[5:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_flat
    assign vram_flat[32*w +: 32] = vram[w];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pal[0]  <= PAL0_RST;
      pal[1]  <= PAL1_RST;
      pal[2]  <= PAL2_RST;
      pal[3]  <= PAL3_RST;
      x_scale <= 7'(X_SCALE_RST - 1);
      y_scale <= 7'(Y_SCALE_RST - 1);
    end else if (wr) begin
      if (address[5:2] == PAL_BASE[5:2] && (BPP == 2 || !address[1]))
        pal[address[1:0]] <= data_in[5:0];
      if (address == SCALE) begin
        x_scale <= data_in[6:0];
        y_scale <= data_in[14:8];
      end
    end
  end

`ifdef VGA_FB_SCROLL_EN
  logic [IW-1:0] scroll_val;
  assign scroll_val = data_in[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) frame_start <= '0;
    else if (wr && address == SCROLL)
      frame_start <= (scroll_val > LAST) ? LAST : scroll_val;
  end
`else
  assign frame_start = '0;
`endif

  // vsync doubles as the previous-cycle sample of vga_vsync_in
  assign vsync_rise = vga_vsync_in & ~vsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      index     <= '0;
      row_start <= '0;
    end else begin
      if (vga_new_scanline) begin
        x_cnt <= '0;
        index <= row_start;
        if (y_cnt == y_scale) begin
          y_cnt     <= '0;
          row_start <= inc_wrap(index);
        end else begin
          y_cnt <= y_cnt + 1'b1;
        end
      end else if (vga_blank) begin
        x_cnt <= '0;
      end else if (x_cnt == x_scale) begin
        index <= inc_wrap(index);
        x_cnt <= '0;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
      if (vsync_rise) begin
        row_start <= frame_start;
        y_cnt     <= '0;
      end
    end
  end

  assign bit_idx = BW'(index) * BW'(BPP);
  assign px      = vram_flat[bit_idx +: BPP];

  always_ff @(posedge clk) begin
    if (rst) begin
      bbggrr <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else begin
      bbggrr <= vga_blank ? '0 : pal[2'(px)];
      hsync  <= vga_hsync_in;
      vsync  <= vga_vsync_in;
    end
  end

  vga_fb_wait_ctrl u_wait (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd),
    .wr_req       (wr),
    .address      (address),
    .vga_blank    (vga_blank),
    .vga_vsync_in (vga_vsync_in),
    .index_zero   (index == '0),
    .data_ready   (data_ready)
  );

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: directed checks of VRAM writes, palette, scanout
// and the three CPU stalls on a BPP=1 and a BPP=2 instance.
module tb_vga_fb_scanout;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] NONE = 2'b11;
  localparam logic [31:0] P0 = 32'h10;
  localparam logic [31:0] P1 = 32'h0B;
`ifdef VGA_FB_SCROLL_EN
  localparam logic [31:0] EXP_SCROLL = 32'h0B;
`else
  localparam logic [31:0] EXP_SCROLL = 32'h10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [9:0]  vga_y;
  logic        vga_blank, vga_new_scanline;
  logic        vga_hsync_in, vga_vsync_in;
  logic [31:0] d_out0, d_out1;
  logic        rdy0, rdy1;
  logic [5:0]  rgb0, rgb1;
  logic        hs0, vs0, hs1, vs1;

  int errs = 0;
  int checks = 0;
  int p;

  always #5 clk = ~clk;

  vga_fb_scanout u0 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(d_out0), .data_ready(rdy0), .vga_y(vga_y),
    .vga_blank(vga_blank), .vga_new_scanline(vga_new_scanline),
    .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in),
    .bbggrr(rgb0), .hsync(hs0), .vsync(vs0)
  );

  vga_fb_scanout #(.PIXEL_COUNT(192), .BPP(2)) u1 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(d_out1), .data_ready(rdy1), .vga_y(vga_y),
    .vga_blank(vga_blank), .vga_new_scanline(vga_new_scanline),
    .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in),
    .bbggrr(rgb1), .hsync(hs1), .vsync(vs1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d,
                        input logic [1:0] sz);
    address = a;
    data_in = d;
    data_write_n = sz;
    step();
    data_write_n = NONE;
  endtask

  task automatic rd_pulse(input logic [5:0] a);
    address = a;
    data_read_n = WORD;
    #1;
  endtask

  task automatic new_line();
    vga_blank = 1'b1;
    vga_new_scanline = 1'b1;
    step();
    vga_new_scanline = 1'b0;
  endtask

  task automatic scan(input int n, input logic [31:0] word,
                      input logic [31:0] c0, input logic [31:0] c1,
                      input string tag);
    new_line();
    vga_blank = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, {26'd0, rgb0}, word[i] ? c1 : c0);
    end
    vga_blank = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    address = '0;
    data_in = '0;
    data_write_n = NONE;
    data_read_n = NONE;
    vga_y = 10'h155;
    vga_blank = 1'b1;
    vga_new_scanline = 1'b0;
    vga_hsync_in = 1'b0;
    vga_vsync_in = 1'b0;
    step();
    step();
    chk("rst_rgb", {26'd0, rgb0}, 32'h0);
    chk("rst_sync", {30'd0, hs0, vs0}, 32'h0);
    chk("rst_ready", {30'd0, rdy0, rdy1}, 32'h3);
    chk("rst_dout", d_out0, 32'h155);
    chk("rst_dout1", d_out1, 32'h155);
    rst = 1'b0;

    bus_wr(6'h34, 32'h0000_7F00, WORD);
    bus_wr(6'h00, 32'hA5A5_A5A5, WORD);
    scan(4, 32'hA5A5_A5A5, P0, P1, "px_a5");
    step();
    chk("blank_rgb", {26'd0, rgb0}, 32'h0);

    bus_wr(6'h00, 32'h0, WORD);
    bus_wr(6'h01, 32'h0000_00FF, BYTE);
    scan(32, 32'h0000_FF00, P0, P1, "px_byte");
    bus_wr(6'h03, 32'h0000_8001, HALF);
    bus_wr(6'h30, 32'h0000_002A, WORD);
    scan(32, 32'h8001_FF00, 32'h2A, P1, "px_half");
    step();

    rd_pulse(6'h00);
    chk("hbl_req", {31'd0, rdy0}, 32'h0);
    step();
    data_read_n = NONE;
    step();
    step();
    chk("hbl_in_blank", {31'd0, rdy0}, 32'h0);
    vga_blank = 1'b0;
    step();
    step();
    chk("hbl_visible", {31'd0, rdy0}, 32'h0);
    vga_blank = 1'b1;
    #1;
    chk("hbl_edge", {31'd0, rdy0}, 32'h0);
    step();
    chk("hbl_release", {31'd0, rdy0}, 32'h1);

    rd_pulse(6'h04);
    chk("px0_req", {31'd0, rdy0}, 32'h0);
    step();
    data_read_n = NONE;
    step();
    chk("px0_wait", {31'd0, rdy0}, 32'h0);
    new_line();
    chk("px0_blank", {31'd0, rdy0}, 32'h0);
    vga_blank = 1'b0;
    step();
    chk("px0_release", {31'd0, rdy0}, 32'h1);
    vga_blank = 1'b1;
    step();

    rd_pulse(6'h08);
    chk("vbl_req", {31'd0, rdy0}, 32'h0);
    step();
    data_read_n = NONE;
    step();
    step();
    chk("vbl_wait", {31'd0, rdy0}, 32'h0);
    vga_vsync_in = 1'b1;
    #1;
    chk("vbl_edge", {30'd0, rdy0, vs0}, 32'h0);
    step();
    chk("vbl_release", {31'd0, rdy0}, 32'h1);
    chk("vs_out", {30'd0, vs0, vs1}, 32'h3);
    vga_vsync_in = 1'b0;
    vga_hsync_in = 1'b1;
    #1;
    chk("hs_pre", {31'd0, hs0}, 32'h0);
    step();
    chk("hs_out", {30'd0, hs0, hs1}, 32'h3);
    vga_hsync_in = 1'b0;
    step();

    address = 6'h00;
    data_in = 32'h8001_FF00;
    data_write_n = WORD;
    data_read_n = WORD;
    #1;
    chk("wr_prio_req", {31'd0, rdy0}, 32'h1);
    step();
    data_write_n = NONE;
    data_read_n = NONE;
    chk("wr_prio_after", {31'd0, rdy0}, 32'h1);

    vga_y = 10'h2A7;
    rd_pulse(6'h10);
    chk("rd_other", {31'd0, rdy0}, 32'h1);
    chk("rd_dout", d_out0, 32'h0000_02A7);
    step();
    data_read_n = NONE;
    chk("rd_other_after", {31'd0, rdy0}, 32'h1);

    rd_pulse(6'h08);
    step();
    data_read_n = NONE;
    chk("rst_pre", {30'd0, rdy0, rdy1}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_stall", {30'd0, rdy0, rdy1}, 32'h3);
    step();
    chk("rst_stall_hold", {31'd0, rdy0}, 32'h1);

    bus_wr(6'h34, 32'h0000_7F00, WORD);
    bus_wr(6'h33, 32'h0000_003F, BYTE);
    bus_wr(6'h00, 32'h0, WORD);
    bus_wr(6'h01, 32'h0000_000C, BYTE);
    bus_wr(6'h2C, 32'hC000_0000, WORD);
    new_line();
    vga_blank = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i < 8 || i >= 190) begin
        p = (i >= 192) ? i - 192 : i;
        chk("bpp2_px", {26'd0, rgb1},
            (p == 5 || p == 191) ? 32'h3F : 32'h10);
      end
    end
    vga_blank = 1'b1;
    step();
    chk("bpp2_blank", {26'd0, rgb1}, 32'h0);

    bus_wr(6'h04, 32'h0000_0100, WORD);
    bus_wr(6'h35, 32'd40, WORD);
    new_line();
    vga_blank = 1'b0;
    step();
    chk("scroll_cur", {26'd0, rgb0}, P0);
    vga_blank = 1'b1;
    vga_vsync_in = 1'b1;
    step();
    vga_vsync_in = 1'b0;
    step();
    new_line();
    vga_blank = 1'b0;
    step();
    chk("scroll_next", {26'd0, rgb0}, EXP_SCROLL);
    vga_blank = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
